// File: rtl/seq_booth_mult_pkg.sv
// Shared types and defaults for the radix-2 Booth sequential multiplier.
package seq_booth_mult_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_ADD  = 2'd1,
      OP_SUB  = 2'd2
   } booth_op_t;

endpackage

// File: rtl/seq_booth_mult_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic shift right of {A, Q, q_m1}. Purely combinational.
module booth_step
   import seq_booth_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH:0] a_i,
   input  logic [WIDTH:0] q_i,
   input  logic           q_m1_i,
   input  logic [WIDTH:0] m_i,
   output logic [WIDTH:0] a_o,
   output logic [WIDTH:0] q_o,
   output logic           q_m1_o
);

   booth_op_t      op;
   logic [WIDTH:0] sum;

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      op = OP_NONE;
      unique case ({q_i[0], q_m1_i})
         2'b01:   op = OP_ADD;
         2'b10:   op = OP_SUB;
         default: op = OP_NONE;
      endcase
   end

   always_comb begin
      sum = a_i;
      unique case (op)
         OP_ADD:  sum = a_i + m_i;
         OP_SUB:  sum = a_i - m_i;
         default: sum = a_i;
      endcase
   end

   // The MSB of the adder result is replicated so the shift stays arithmetic.
   assign a_o    = {sum[WIDTH], sum[WIDTH:1]};
   assign q_o    = {sum[0], q_i[WIDTH:1]};
   assign q_m1_o = q_i[0];

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation,
// one Booth step per clock, valid/ready on both sides with back-to-back issue.
module seq_booth_mult
   import seq_booth_mult_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int CNT_W = $clog2(WIDTH + 2);

   state_t             state_q, state_d;
   logic [WIDTH:0]     m_q, m_d;
   logic [WIDTH:0]     q_q, q_d;
   logic [WIDTH:0]     a_q, a_d;
   logic               qm1_q, qm1_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic [WIDTH:0]     step_a, step_q;
   logic               step_qm1;
   logic [WIDTH:0]     m_ext, q_ext;
   logic               accept;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .a_i    (a_q),
      .q_i    (q_q),
      .q_m1_i (qm1_q),
      .m_i    (m_q),
      .a_o    (step_a),
      .q_o    (step_q),
      .q_m1_o (step_qm1)
   );

   // Operands widen by one bit so unsigned values look positive to the Booth core.
   assign m_ext = {signed_mode & multiplicand[WIDTH-1], multiplicand};
   assign q_ext = {signed_mode & multiplier[WIDTH-1], multiplier};

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_CALC);
   assign product   = product_q;

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      q_d       = q_q;
      a_d       = a_q;
      qm1_d     = qm1_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) begin
               m_d     = m_ext;
               q_d     = q_ext;
               a_d     = '0;
               qm1_d   = 1'b0;
               cnt_d   = CNT_W'(WIDTH + 1);
               state_d = S_CALC;
            end else if ((state_q == S_DONE) && out_ready) begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            a_d   = step_a;
            q_d   = step_q;
            qm1_d = step_qm1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Full {A,Q} is 2*WIDTH+2 bits; its low 2*WIDTH bits are the exact product.
               product_d = {step_a[WIDTH-2:0], step_q};
               state_d   = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         q_q       <= '0;
         a_q       <= '0;
         qm1_q     <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         q_q       <= q_d;
         a_q       <= a_d;
         qm1_q     <= qm1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed self-checking bench for seq_booth_mult at WIDTH=8 and WIDTH=16.
module tb_seq_booth_mult;

   logic clk = 1'b0;
   logic rst_b;

   logic        in_valid8, in_ready8, signed_mode8, out_valid8, out_ready8, busy8;
   logic [7:0]  mcand8, mplier8;
   logic [15:0] product8;

   logic        in_valid16, in_ready16, signed_mode16, out_valid16, out_ready16, busy16;
   logic [15:0] mcand16, mplier16;
   logic [31:0] product16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_booth_mult #(.WIDTH(8)) u_dut8 (
      .clk          (clk),
      .rst_b        (rst_b),
      .in_valid     (in_valid8),
      .in_ready     (in_ready8),
      .signed_mode  (signed_mode8),
      .multiplicand (mcand8),
      .multiplier   (mplier8),
      .out_valid    (out_valid8),
      .out_ready    (out_ready8),
      .product      (product8),
      .busy         (busy8)
   );

   seq_booth_mult #(.WIDTH(16)) u_dut16 (
      .clk          (clk),
      .rst_b        (rst_b),
      .in_valid     (in_valid16),
      .in_ready     (in_ready16),
      .signed_mode  (signed_mode16),
      .multiplicand (mcand16),
      .multiplier   (mplier16),
      .out_valid    (out_valid16),
      .out_ready    (out_ready16),
      .product      (product16),
      .busy         (busy16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges from the accept edge until out_valid, and busy cycles on the way.
   task automatic wait_done(input bit wide, output int lat, output int busy_n);
      lat    = 0;
      busy_n = 0;
      while (!(wide ? out_valid16 : out_valid8) && lat < 60) begin
         if (wide ? busy16 : busy8) busy_n++;
         tick();
         lat++;
      end
   endtask

   task automatic run8(input string tag, input bit s, input logic [7:0] m, input logic [7:0] q,
                       input logic [15:0] exp);
      int lat, bn;
      signed_mode8 = s;
      mcand8       = m;
      mplier8      = q;
      in_valid8    = 1'b1;
      out_ready8   = 1'b1;
      tick();
      in_valid8    = 1'b0;
      wait_done(1'b0, lat, bn);
      check({tag, "_lat"}, 64'(lat), 64'(9));
      check({tag, "_busy"}, 64'(bn), 64'(9));
      check({tag, "_prod"}, 64'(product8), 64'(exp));
      tick();
      check({tag, "_drop"}, 64'(out_valid8), 64'(0));
   endtask

   task automatic run16(input string tag, input bit s, input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] exp);
      int lat, bn;
      signed_mode16 = s;
      mcand16       = m;
      mplier16      = q;
      in_valid16    = 1'b1;
      out_ready16   = 1'b1;
      tick();
      in_valid16    = 1'b0;
      wait_done(1'b1, lat, bn);
      check({tag, "_lat"}, 64'(lat), 64'(17));
      check({tag, "_prod"}, 64'(product16), 64'(exp));
      tick();
      check({tag, "_drop"}, 64'(out_valid16), 64'(0));
   endtask

   logic [7:0]  sm_m   [20];
   logic [7:0]  sm_q   [20];
   bit          sm_s   [20];
   logic [15:0] sm_exp [20];

   initial begin
      int lat, bn, mi, qi;

      rst_b         = 1'b0;
      in_valid8     = 1'b0;
      signed_mode8  = 1'b0;
      mcand8        = '0;
      mplier8       = '0;
      out_ready8    = 1'b1;
      in_valid16    = 1'b0;
      signed_mode16 = 1'b0;
      mcand16       = '0;
      mplier16      = '0;
      out_ready16   = 1'b1;

      // Reset state
      #23;
      check("rst_out_valid", 64'(out_valid8), 64'(0));
      check("rst_product", 64'(product8), 64'(0));
      check("rst_busy", 64'(busy8), 64'(0));
      check("rst_in_ready", 64'(in_ready8), 64'(1));
      rst_b = 1'b1;
      tick();

      // Unsigned maximum, latency and busy length
      run8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);

      // Signed corners and mode sensitivity
      run8("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
      run8("s_m3_5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
      run8("u_80_02", 1'b0, 8'h80, 8'h02, 16'h0100);
      run8("s_80_02", 1'b1, 8'h80, 8'h02, 16'hFF00);

      // Backpressure: hold out_ready low in S_DONE with new operands pending
      signed_mode8 = 1'b0;
      mcand8       = 8'd3;
      mplier8      = 8'd4;
      in_valid8    = 1'b1;
      out_ready8   = 1'b0;
      tick();
      in_valid8    = 1'b0;
      wait_done(1'b0, lat, bn);
      check("bp_first_lat", 64'(lat), 64'(9));
      mcand8    = 8'd7;
      mplier8   = 8'd6;
      in_valid8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid_hold", 64'(out_valid8), 64'(1));
         check("bp_prod_hold", 64'(product8), 64'(16'h000C));
         check("bp_in_ready", 64'(in_ready8), 64'(0));
         tick();
      end
      out_ready8 = 1'b1;
      #1;
      check("bp_in_ready_up", 64'(in_ready8), 64'(1));
      tick();
      in_valid8 = 1'b0;
      check("bp_reaccept_busy", 64'(busy8), 64'(1));
      wait_done(1'b0, lat, bn);
      check("bp_second_lat", 64'(lat), 64'(9));
      check("bp_second_prod", 64'(product8), 64'(16'h002A));
      tick();

      // Reset during the 4th S_CALC cycle
      signed_mode8 = 1'b0;
      mcand8       = 8'd100;
      mplier8      = 8'd100;
      in_valid8    = 1'b1;
      tick();
      in_valid8 = 1'b0;
      tick();
      tick();
      tick();
      check("mid_busy_before", 64'(busy8), 64'(1));
      rst_b = 1'b0;
      #1;
      check("mid_out_valid", 64'(out_valid8), 64'(0));
      check("mid_product", 64'(product8), 64'(0));
      check("mid_in_ready", 64'(in_ready8), 64'(1));
      check("mid_busy", 64'(busy8), 64'(0));
      tick();
      tick();
      rst_b = 1'b1;
      tick();
      run8("post_rst_12_11", 1'b0, 8'd12, 8'd11, 16'h0084);

      // Back-to-back stream against a reference model
      for (int k = 0; k < 20; k++) begin
         sm_s[k] = 1'($urandom_range(0, 1));
         sm_m[k] = 8'($urandom);
         sm_q[k] = 8'($urandom);
         if (sm_s[k]) begin
            mi = int'($signed(sm_m[k]));
            qi = int'($signed(sm_q[k]));
         end else begin
            mi = int'(sm_m[k]);
            qi = int'(sm_q[k]);
         end
         sm_exp[k] = 16'(mi * qi);
      end
      out_ready8   = 1'b1;
      signed_mode8 = sm_s[0];
      mcand8       = sm_m[0];
      mplier8      = sm_q[0];
      in_valid8    = 1'b1;
      tick();
      for (int k = 0; k < 20; k++) begin
         if (k < 19) begin
            signed_mode8 = sm_s[k+1];
            mcand8       = sm_m[k+1];
            mplier8      = sm_q[k+1];
         end else begin
            in_valid8 = 1'b0;
         end
         wait_done(1'b0, lat, bn);
         check($sformatf("stream%0d_lat", k), 64'(lat), 64'(9));
         check($sformatf("stream%0d_prod", k), 64'(product8), 64'(sm_exp[k]));
         tick();
      end
      check("stream_idle", 64'(out_valid8), 64'(0));

      // WIDTH=16 corners
      run16("w16_s_8000_7fff", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000);
      run16("w16_u_ffff_0001", 1'b0, 16'hFFFF, 16'h0001, 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
